// File: rtl/hack_alu_if.sv
// Valid/ready channel bundle for the pipelined Hack ALU.
// The master side drives operations and consumes results. The slave side is the ALU.
interface hack_alu_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [TAG_W-1:0] out_tag;
  logic             zr;
  logic             ng;
  logic             cy;
  logic             ov;

  modport master (
    output in_valid, x, y, op, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, zr, ng, cy, ov
  );

  modport slave (
    input  in_valid, x, y, op, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, zr, ng, cy, ov
  );
endinterface

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with a valid/ready channel on each side.
// S1 holds the preconditioned operands (zero/invert applied) together with f, no and the tag.
// S2 holds the final result, the tag and the zr/ng/cy/ov flags.
// The pipeline holds up to two operations and runs at one operation per cycle when unstalled.
module hack_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  hack_alu_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  // Operand conditioning: optionally force the operand to zero, then optionally invert it.
  function automatic logic [WIDTH-1:0] precondition(
    input logic [WIDTH-1:0] v,
    input logic             zero,
    input logic             inv
  );
    logic [WIDTH-1:0] t;
    t = zero ? {WIDTH{1'b0}} : v;
    return inv ? ~t : t;
  endfunction

  // Stall control
  logic             s2_en_s;
  logic             s1_en_s;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_xs_q, s1_xs_d;
  logic [WIDTH-1:0] s1_ys_q, s1_ys_d;
  logic             s1_f_q, s1_f_d;
  logic             s1_no_q, s1_no_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // ALU datapath between the stages
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] r_s;
  logic             c_s;
  logic             ov_s;
  logic [WIDTH-1:0] res_s;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_out_q, s2_out_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_zr_q, s2_zr_d;
  logic             s2_ng_q, s2_ng_d;
  logic             s2_cy_q, s2_cy_d;
  logic             s2_ov_q, s2_ov_d;

  // Each stage advances when it is empty or when the stage after it is draining.
  always_comb begin
    s2_en_s = !s2_valid_q || bus.out_ready;
    s1_en_s = !s1_valid_q || s2_en_s;
  end

  // S1 next state: capture conditioned operands on an input transfer. Hold otherwise.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_xs_d    = s1_xs_q;
    s1_ys_d    = s1_ys_q;
    s1_f_d     = s1_f_q;
    s1_no_d    = s1_no_q;
    s1_tag_d   = s1_tag_q;
    if (s1_en_s) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_xs_d  = precondition(bus.x, bus.op[5], bus.op[4]);
        s1_ys_d  = precondition(bus.y, bus.op[3], bus.op[2]);
        s1_f_d   = bus.op[1];
        s1_no_d  = bus.op[0];
        s1_tag_d = bus.in_tag;
      end else begin
        s1_xs_d  = s1_xs_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // ALU function. Carry and overflow are taken before the optional output inversion.
  always_comb begin
    sum_s = {1'b0, s1_xs_q} + {1'b0, s1_ys_q};
    if (s1_f_q) begin
      r_s = sum_s[WIDTH-1:0];
      c_s = sum_s[WIDTH];
    end else begin
      r_s = s1_xs_q & s1_ys_q;
      c_s = 1'b0;
    end
    ov_s  = s1_f_q & (s1_xs_q[MSB] == s1_ys_q[MSB]) & (r_s[MSB] != s1_xs_q[MSB]);
    res_s = s1_no_q ? ~r_s : r_s;
  end

  // S2 next state: move the S1 result forward when S2 may advance. Hold otherwise.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    s2_tag_d   = s2_tag_q;
    s2_zr_d    = s2_zr_q;
    s2_ng_d    = s2_ng_q;
    s2_cy_d    = s2_cy_q;
    s2_ov_d    = s2_ov_q;
    if (s2_en_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_out_d = res_s;
        s2_tag_d = s1_tag_q;
        s2_zr_d  = (res_s == {WIDTH{1'b0}});
        s2_ng_d  = res_s[MSB];
        s2_cy_d  = c_s;
        s2_ov_d  = ov_s;
      end else begin
        s2_out_d = s2_out_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // S1 register bank; reset empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_xs_q    <= {WIDTH{1'b0}};
      s1_ys_q    <= {WIDTH{1'b0}};
      s1_f_q     <= 1'b0;
      s1_no_q    <= 1'b0;
      s1_tag_q   <= {TAG_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_xs_q    <= s1_xs_d;
      s1_ys_q    <= s1_ys_d;
      s1_f_q     <= s1_f_d;
      s1_no_q    <= s1_no_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  // S2 register bank; reset clears the result, the tag and all flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_out_q   <= {WIDTH{1'b0}};
      s2_tag_q   <= {TAG_W{1'b0}};
      s2_zr_q    <= 1'b0;
      s2_ng_q    <= 1'b0;
      s2_cy_q    <= 1'b0;
      s2_ov_q    <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_out_q   <= s2_out_d;
      s2_tag_q   <= s2_tag_d;
      s2_zr_q    <= s2_zr_d;
      s2_ng_q    <= s2_ng_d;
      s2_cy_q    <= s2_cy_d;
      s2_ov_q    <= s2_ov_d;
    end
  end

  // in_ready follows out_ready combinationally so a full pipeline can still stream.
  assign bus.in_ready  = s1_en_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.out       = s2_out_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.zr        = s2_zr_q;
  assign bus.ng        = s2_ng_q;
  assign bus.cy        = s2_cy_q;
  assign bus.ov        = s2_ov_q;

endmodule
